// File: rtl/score_keeper.sv
// Match controller: holds both scores, sequences idle/serve/play/game-over,
// gates ball motion and issues the one-cycle serve pulse.
module score_keeper #(
    parameter int unsigned SCORE_W      = 4,
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned CNT_W        = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               p1_scored,
    input  logic               p2_scored,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               ball_enable,
    output logic               serve,
    output logic               serve_dir,
    output logic               game_over,
    output logic               winner
);

    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_WAIT = 2'd1,
        PLAY       = 2'd2,
        GAME_OVER  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   countdown;
    logic [SCORE_W-1:0] p1_inc;
    logic [SCORE_W-1:0] p2_inc;

    assign p1_inc = p1_score + SCORE_W'(1);
    assign p2_inc = p2_score + SCORE_W'(1);

    // Single registered FSM; serve defaults low so it only ever pulses one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            countdown   <= '0;
            p1_score    <= '0;
            p2_score    <= '0;
            ball_enable <= 1'b0;
            serve       <= 1'b0;
            serve_dir   <= 1'b1;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            serve <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SERVE_WAIT;
                        p1_score  <= '0;
                        p2_score  <= '0;
                        countdown <= '0;
                        serve_dir <= 1'b1;
                    end
                end
                SERVE_WAIT: begin
                    if (frame_tick) begin
                        if (countdown == LAST_CNT) begin
                            state       <= PLAY;
                            serve       <= 1'b1;
                            ball_enable <= 1'b1;
                            countdown   <= '0;
                        end else begin
                            countdown <= countdown + CNT_W'(1);
                        end
                    end
                end
                PLAY: begin
                    if (p1_scored && p2_scored) begin
                        state       <= SERVE_WAIT;
                        ball_enable <= 1'b0;
                        countdown   <= '0;
                    end else if (p1_scored) begin
                        p1_score    <= p1_inc;
                        serve_dir   <= 1'b0;
                        ball_enable <= 1'b0;
                        countdown   <= '0;
                        if (p1_inc == WIN_VAL) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b0;
                        end else begin
                            state <= SERVE_WAIT;
                        end
                    end else if (p2_scored) begin
                        p2_score    <= p2_inc;
                        serve_dir   <= 1'b1;
                        ball_enable <= 1'b0;
                        countdown   <= '0;
                        if (p2_inc == WIN_VAL) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b1;
                        end else begin
                            state <= SERVE_WAIT;
                        end
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        state     <= SERVE_WAIT;
                        p1_score  <= '0;
                        p2_score  <= '0;
                        game_over <= 1'b0;
                        serve_dir <= 1'b1;
                        countdown <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed literal checks plus randomized play
// compared every cycle against a match-rules model.
module tb_score_keeper;

    localparam int unsigned SCORE_W      = 4;
    localparam int unsigned WIN_SCORE    = 7;
    localparam int unsigned SERVE_FRAMES = 3;
    localparam int unsigned CNT_W        = 7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, frame_tick = 1'b0, p1_scored = 1'b0, p2_scored = 1'b0;
    logic [SCORE_W-1:0] p1_score, p2_score;
    logic ball_enable, serve, serve_dir, game_over, winner;

    int total = 0;
    int bad = 0;
    bit cmp_on = 1'b0;

    score_keeper #(
        .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE),
        .SERVE_FRAMES(SERVE_FRAMES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .frame_tick(frame_tick),
        .p1_scored(p1_scored), .p2_scored(p2_scored),
        .p1_score(p1_score), .p2_score(p2_score), .ball_enable(ball_enable),
        .serve(serve), .serve_dir(serve_dir), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Match-rules model: phase names and point bookkeeping.
    typedef enum int {M_IDLE, M_WAIT, M_PLAY, M_OVER} phase_t;
    phase_t m_phase;
    int m_p1, m_p2, m_frames;
    bit m_serve, m_dir, m_winner;

    task automatic new_match();
        m_p1 = 0; m_p2 = 0; m_dir = 1'b1; m_frames = 0; m_phase = M_WAIT;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = M_IDLE; m_p1 = 0; m_p2 = 0; m_frames = 0;
            m_serve = 1'b0; m_dir = 1'b1; m_winner = 1'b0;
        end else begin
            m_serve = 1'b0;
            if (m_phase == M_IDLE) begin
                if (start) new_match();
            end else if (m_phase == M_WAIT) begin
                if (frame_tick) begin
                    m_frames++;
                    if (m_frames == SERVE_FRAMES) begin
                        m_phase = M_PLAY; m_serve = 1'b1; m_frames = 0;
                    end
                end
            end else if (m_phase == M_PLAY) begin
                if (p1_scored != p2_scored) begin
                    if (p1_scored) begin m_p1++; m_dir = 1'b0; end
                    else begin m_p2++; m_dir = 1'b1; end
                    m_frames = 0;
                    if (m_p1 == WIN_SCORE || m_p2 == WIN_SCORE) begin
                        m_phase = M_OVER; m_winner = (m_p2 == WIN_SCORE);
                    end else begin
                        m_phase = M_WAIT;
                    end
                end else if (p1_scored) begin
                    m_phase = M_WAIT; m_frames = 0;
                end
            end else begin
                if (start) new_match();
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on && reset_n) begin
            chk("cyc_p1_score", int'(p1_score), m_p1);
            chk("cyc_p2_score", int'(p2_score), m_p2);
            chk("cyc_ball_enable", int'(ball_enable), int'(m_phase == M_PLAY));
            chk("cyc_serve", int'(serve), int'(m_serve));
            chk("cyc_serve_dir", int'(serve_dir), int'(m_dir));
            chk("cyc_game_over", int'(game_over), int'(m_phase == M_OVER));
            if (m_phase == M_OVER) chk("cyc_winner", int'(winner), int'(m_winner));
        end
    end

    task automatic cyc(input logic st, input logic ft, input logic a, input logic b);
        @(negedge clk);
        start = st; frame_tick = ft; p1_scored = a; p2_scored = b;
        @(posedge clk);
        #1;
    endtask

    task automatic serve_wait();
        int n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            n++;
            if (serve) break;
        end
        chk("serve_wait_ticks", n, 3);
        chk("serve_ball_enable", int'(ball_enable), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("serve_one_cycle", int'(serve), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_p1"}, int'(p1_score), 0);
        chk({tag, "_p2"}, int'(p2_score), 0);
        chk({tag, "_ball"}, int'(ball_enable), 0);
        chk({tag, "_serve"}, int'(serve), 0);
        chk({tag, "_dir"}, int'(serve_dir), 1);
        chk({tag, "_over"}, int'(game_over), 0);
        chk({tag, "_winner"}, int'(winner), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;
        cmp_on = 1'b1;

        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("idle_p1_ignored", int'(p1_score), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_ball_off", int'(ball_enable), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wait_p1_ignored", int'(p1_score), 0);
        serve_wait();

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("play_start_ignored", int'(ball_enable), 1);

        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("p1pt_p1", int'(p1_score), 1);
        chk("p1pt_p2", int'(p2_score), 0);
        chk("p1pt_ball", int'(ball_enable), 0);
        chk("p1pt_dir", int'(serve_dir), 0);
        serve_wait();

        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("both_p1", int'(p1_score), 1);
        chk("both_p2", int'(p2_score), 0);
        chk("both_ball", int'(ball_enable), 0);
        chk("both_dir", int'(serve_dir), 0);
        serve_wait();

        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            if (i < 6) serve_wait();
        end
        chk("win_p2", int'(p2_score), 7);
        chk("win_over", int'(game_over), 1);
        chk("win_winner", int'(winner), 1);
        chk("win_ball", int'(ball_enable), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("over_p1_held", int'(p1_score), 1);
        chk("over_p2_held", int'(p2_score), 7);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_p1", int'(p1_score), 0);
        chk("restart_p2", int'(p2_score), 0);
        chk("restart_over", int'(game_over), 0);
        serve_wait();

        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            serve_wait();
        end
        chk("pre_reset_p1", int'(p1_score), 3);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(posedge clk);
        #1;
        chk("midreset_no_serve", int'(serve), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 20) == 0, ($urandom % 3) == 0,
                ($urandom % 8) == 0, ($urandom % 8) == 0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cmp_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
